// File: rtl/alu_front_end.sv
`default_nettype none
// ============================================================================
//  Module   : alu_front_end
//  Purpose  : Panel front end for the ALU board. Synchronizes and debounces
//             the three load buttons, latches operand A, operand B and the
//             opcode from the switches, and publishes the ALU result to the
//             LEDs on request once all three fields have been loaded.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_front_end #(
    parameter int NB_DATA   = 8,
    parameter int NB_OPCODE = 6,
    parameter int DB_CYCLES = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NB_DATA-1:0]   i_switches,
    input  logic [2:0]           i_botones,
    input  logic                 i_out_enable,
    input  logic [NB_DATA-1:0]   i_alu_result,
    output logic [NB_DATA-1:0]   o_alu_a,
    output logic [NB_DATA-1:0]   o_alu_b,
    output logic [NB_OPCODE-1:0] o_alu_op,
    output logic [NB_DATA-1:0]   o_leds,
    output logic                 o_result_valid,
    output logic [2:0]           o_loaded
);

    // The counter only has to hold values up to DB_CYCLES-1: the count that
    // would reach DB_CYCLES commits the new level instead of being stored.
    localparam int                 c_CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DB_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [0:0] c_ST_WAIT  = 1'b0;
    localparam logic [0:0] c_ST_READY = 1'b1;

    logic [2:0] w_load_pulse;
    logic [0:0] r_state;
    logic       w_publish;

    // One synchronizer / debouncer / rising-edge detector per button.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            logic               r_sync1;
            logic               r_sync2;
            logic               r_db;
            logic               r_db_d;
            logic [c_CNT_W-1:0] r_cnt;

            // Sync the raw level, then accept a change only after DB_CYCLES stable samples.
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_db    <= 1'b0;
                    r_db_d  <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= i_botones[gi];
                    r_sync2 <= r_sync1;
                    r_db_d  <= r_db;
                    if (r_sync2 == r_db) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_db  <= r_sync2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
            end

            // Press is recognized on the debounced rising edge only.
            assign w_load_pulse[gi] = r_db & ~r_db_d;
        end
    endgenerate

    assign w_publish = (r_state == c_ST_READY) && i_out_enable;

    // Operand/opcode capture, loaded flags and result publication.
    always_ff @(posedge clock) begin
        if (reset) begin
            o_alu_a        <= '0;
            o_alu_b        <= '0;
            o_alu_op       <= '0;
            o_leds         <= '0;
            o_result_valid <= 1'b0;
            o_loaded       <= 3'b000;
        end else begin
            if (w_load_pulse[0]) o_alu_a  <= i_switches;
            if (w_load_pulse[1]) o_alu_b  <= i_switches;
            if (w_load_pulse[2]) o_alu_op <= i_switches[NB_OPCODE-1:0];
            // A publish consumes the loaded set, but a load landing on the
            // same edge belongs to the next set and must survive.
            o_loaded       <= (w_publish ? 3'b000 : o_loaded) | w_load_pulse;
            o_result_valid <= w_publish;
            // i_alu_result still reflects the pre-load operands on this edge.
            if (w_publish) o_leds <= i_alu_result;
        end
    end

    // WAIT until all three fields are loaded, then READY until one publish.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_WAIT;
        end else begin
            case (r_state)
                c_ST_WAIT:  if (o_loaded == 3'b111) r_state <= c_ST_READY;
                c_ST_READY: if (i_out_enable)       r_state <= c_ST_WAIT;
                default:                            r_state <= c_ST_WAIT;
            endcase
        end
    end

endmodule
`default_nettype wire
